// File: rtl/mcs51_ser_pkg.sv
// Shared encodings for the MCS-51 serial port: SCON mode codes, transmitter
// state encoding and frame-length constants.
package mcs51_ser_pkg;

   localparam logic [1:0] MODE_0 = 2'b00;
   localparam logic [1:0] MODE_1 = 2'b01;
   localparam logic [1:0] MODE_2 = 2'b10;
   localparam logic [1:0] MODE_3 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_NINTH = 3'd4,
      ST_STOP  = 3'd5
   } tx_state_e;

   localparam int FRAME_BITS_8 = 10;
   localparam int FRAME_BITS_9 = 11;

   // Bit periods in one frame, start and stop included.
   function automatic int frame_bits(input logic nine_bit);
      return nine_bit ? FRAME_BITS_9 : FRAME_BITS_8;
   endfunction

endpackage

// File: rtl/_ser_tick16.sv
// OVS-modulo oversample tick counter; bit_done_o marks the OVS-th tick of a
// bit period. Shared by the serial transmitter and receiver.
module _ser_tick16 #(
   parameter int OVS = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic tick_i,
   output logic bit_done_o
);

   localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_done_o = tick_i && !clr_i && (cnt_q == CW'(OVS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = bit_done_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/_ser_tx.sv
// MCS-51 UART transmitter for modes 1/2/3: serialises SBUF LSB-first with
// start, optional TB8 and stop bits, raising TI at the start of the stop bit.
module _ser_tx
   import mcs51_ser_pkg::*;
#(
   parameter int OVS = 16,
   parameter int DW  = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [1:0]    MODE,
   input  logic          TB8,
   input  logic          TX_TICK,
   input  logic          WR,
   input  logic [DW-1:0] DIN,
   output logic          TXD,
   output logic          TI_SET,
   output logic          BUSY,
   output tx_state_e     DBG_STATE
);

   localparam int BCW = (DW > 2) ? $clog2(DW) : 1;

   tx_state_e      state_q, state_d;
   logic [DW-1:0]  shift_q, shift_d;
   logic [BCW-1:0] bit_q, bit_d;
   logic           ninth_q, ninth_d;
   logic           nine_q, nine_d;
   logic           txd_q, txd_d;
   logic           ti_q, ti_d;
   logic           busy_q, busy_d;
   logic           cnt_clr;
   logic           bit_done;

   // Counter is held clear until the arming tick so the start bit gets a full OVS ticks.
   assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_ARMED);

   _ser_tick16 #(.OVS(OVS)) u_tick (
      .CLK        (CLK),
      .RST        (RST),
      .clr_i      (cnt_clr),
      .tick_i     (TX_TICK),
      .bit_done_o (bit_done)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      ninth_d = ninth_q;
      nine_d  = nine_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      ti_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (WR && (MODE != MODE_0)) begin
               shift_d = DIN;
               ninth_d = TB8;
               nine_d  = MODE[1];
               busy_d  = 1'b1;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (TX_TICK) begin
               txd_d   = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) begin
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               if (bit_q == BCW'(DW - 1)) begin
                  if (nine_q) begin
                     txd_d   = ninth_q;
                     state_d = ST_NINTH;
                  end else begin
                     txd_d   = 1'b1;
                     ti_d    = 1'b1;
                     state_d = ST_STOP;
                  end
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         ST_NINTH: begin
            if (bit_done) begin
               txd_d   = 1'b1;
               ti_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         ninth_q <= 1'b0;
         nine_q  <= 1'b0;
         txd_q   <= 1'b1;
         ti_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         ninth_q <= ninth_d;
         nine_q  <= nine_d;
         txd_q   <= txd_d;
         ti_q    <= ti_d;
         busy_q  <= busy_d;
      end
   end

   assign TXD       = txd_q;
   assign TI_SET    = ti_q;
   assign BUSY      = busy_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb__ser_tx.sv
// Directed bench for the UART transmitter: expected line bits are queued when
// a byte is written and compared at the first and last tick of each bit period.
module tb__ser_tx;
   import mcs51_ser_pkg::*;

   localparam int OVS = 16;
   localparam int DW  = 8;
   localparam int TICK_PERIOD = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    MODE;
   logic          TB8;
   logic          TX_TICK;
   logic          WR;
   logic [DW-1:0] DIN;
   logic          TXD;
   logic          TI_SET;
   logic          BUSY;
   tx_state_e     DBG_STATE;

   logic [0:0] exp_q[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   _ser_tx #(.OVS(OVS), .DW(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .MODE      (MODE),
      .TB8       (TB8),
      .TX_TICK   (TX_TICK),
      .WR        (WR),
      .DIN       (DIN),
      .TXD       (TXD),
      .TI_SET    (TI_SET),
      .BUSY      (BUSY),
      .DBG_STATE (DBG_STATE)
   );

   // clock
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // one clock cycle of stimulus; returns 1 time unit after the edge
   task automatic cyc(input logic t, input logic w, input logic [DW-1:0] d);
      TX_TICK = t;
      WR      = w;
      DIN     = d;
      @(posedge CLK);
      #1;
      TX_TICK = 1'b0;
      WR      = 1'b0;
   endtask

   // driver: SBUF write, with expected frame pushed to the scoreboard
   task automatic write_byte(input logic [1:0] mode, input logic tb8,
                             input logic [DW-1:0] d, input logic coincident_tick);
      MODE = mode;
      TB8  = tb8;
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
      if (mode[1]) exp_q.push_back(tb8);
      exp_q.push_back(1'b1);
      cyc(coincident_tick, 1'b1, d);
   endtask

   // run a frame with a tick every TICK_PERIOD clocks; the first tick arms it
   task automatic run_frame(input int len, input int tog_tick, input int wr_tick,
                            input int abort_tick);
      int   tick_idx = -1;
      int   ti_cnt = 0;
      int   ti_tick = -1;
      int   c = 0;
      logic pend_wr = 1'b0;
      logic t;
      while (BUSY === 1'b1 && c < TICK_PERIOD * (len * OVS + 8)) begin
         t = ((c % TICK_PERIOD) == TICK_PERIOD - 1);
         c++;
         cyc(t, pend_wr, 8'hFF);
         pend_wr = 1'b0;
         if (TI_SET === 1'b1) begin
            ti_cnt++;
            ti_tick = tick_idx + (t ? 1 : 0);
         end
         if (t) begin
            tick_idx++;
            if (tick_idx == wr_tick) pend_wr = 1'b1;
            if (tick_idx == tog_tick) TB8 = ~TB8;
            if (exp_q.size() > 0) begin
               if (tick_idx % OVS == 0) chk("bit_first", 32'(TXD), 32'(exp_q[0]));
               if (tick_idx % OVS == OVS - 1) begin
                  chk("bit_last", 32'(TXD), 32'(exp_q[0]));
                  void'(exp_q.pop_front());
               end
            end
            if (tick_idx == abort_tick) begin
               RST = 1'b1;
               #1;
               chk("abort_txd", 32'(TXD), 32'd1);
               chk("abort_busy", 32'(BUSY), 32'd0);
               chk("abort_ti", 32'(TI_SET), 32'd0);
               chk("abort_ti_cnt", 32'(ti_cnt), 32'd0);
               chk("abort_state", 32'(DBG_STATE), 32'(ST_IDLE));
               exp_q.delete();
               @(posedge CLK);
               @(posedge CLK);
               #1;
               RST = 1'b0;
               return;
            end
         end
      end
      chk("busy_fell", 32'(BUSY), 32'd0);
      chk("busy_fall_tick", 32'(tick_idx), 32'(len * OVS));
      chk("ti_count", 32'(ti_cnt), 32'd1);
      chk("ti_tick", 32'(ti_tick), 32'((len - 1) * OVS));
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("idle_txd", 32'(TXD), 32'd1);
      chk("idle_state", 32'(DBG_STATE), 32'(ST_IDLE));
      exp_q.delete();
      repeat (3) cyc(1'b0, 1'b0, '0);
   endtask

   initial begin
      int bad;
      RST = 1'b1; MODE = MODE_1; TB8 = 1'b0; TX_TICK = 1'b0; WR = 1'b0; DIN = '0;
      #1;
      chk("rst_txd", 32'(TXD), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_ti", 32'(TI_SET), 32'd0);
      chk("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      cyc(1'b0, 1'b0, '0);

      // mode 1, 0xA5
      write_byte(MODE_1, 1'b0, 8'hA5, 1'b0);
      chk("m1_busy_after_wr", 32'(BUSY), 32'd1);
      chk("m1_armed", 32'(DBG_STATE), 32'(ST_ARMED));
      run_frame(frame_bits(1'b0), -1, -1, -1);

      // mode 3, TB8=1, 0x3C, TB8 flipped mid-frame
      write_byte(MODE_3, 1'b1, 8'h3C, 1'b0);
      run_frame(frame_bits(1'b1), 40, -1, -1);

      // write while busy during bit 3 of 0x00
      write_byte(MODE_1, 1'b0, 8'h00, 1'b0);
      run_frame(frame_bits(1'b0), -1, 4 * OVS + 2, -1);
      chk("wwb_busy", 32'(BUSY), 32'd0);

      // mode 0 writes ignored for 200 ticks
      MODE = MODE_0;
      cyc(1'b0, 1'b1, 8'h55);
      bad = 0;
      for (int i = 0; i < 200 * TICK_PERIOD; i++) begin
         cyc((i % TICK_PERIOD) == TICK_PERIOD - 1, 1'b0, '0);
         if (TXD !== 1'b1 || BUSY !== 1'b0 || TI_SET !== 1'b0) bad++;
      end
      chk("mode0_ignored", 32'(bad), 32'd0);
      chk("mode0_state", 32'(DBG_STATE), 32'(ST_IDLE));

      // tick coincident with WR does not arm
      write_byte(MODE_1, 1'b0, 8'h01, 1'b1);
      chk("coinc_txd_high", 32'(TXD), 32'd1);
      chk("coinc_armed", 32'(DBG_STATE), 32'(ST_ARMED));
      run_frame(frame_bits(1'b0), -1, -1, -1);

      // reset during data bit 5, then a clean frame
      write_byte(MODE_2, 1'b0, 8'h5A, 1'b0);
      run_frame(frame_bits(1'b1), -1, -1, 6 * OVS + 4);
      chk("post_rst_busy", 32'(BUSY), 32'd0);
      write_byte(MODE_1, 1'b0, 8'h81, 1'b0);
      run_frame(frame_bits(1'b0), -1, -1, -1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
